// File: rtl/led_pattern_sequencer.sv
// LED sequencer: mirrors the slide switches when idle and plays one of four
// timed patterns (fill, walk, blink, rotate) after a start pulse.
module led_pattern_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] SW,
  input  logic [1:0]  mode,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] LED,
  output logic        busy,
  output logic        done,
  output logic [4:0]  step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       M_FILL   = 2'b00;
  localparam logic [1:0]       M_WALK   = 2'b01;
  localparam logic [1:0]       M_BLINK  = 2'b10;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [15:0]      led_q, led_d;
  logic [15:0]      pat_q, pat_d;
  logic [1:0]       mode_q, mode_d;
  logic [4:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (state_q == S_RUN) && (cnt_q == TICK_MAX);

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        led_d = SW;
        // stop wins over a simultaneous start, so start is only honoured alone
        if (start && !stop) begin
          mode_d  = mode;
          pat_d   = SW;
          step_d  = 5'd0;
          cnt_d   = '0;
          state_d = S_RUN;
          case (mode)
            M_FILL:  led_d = 16'h0000;
            M_WALK:  led_d = 16'h0001;
            default: led_d = SW;
          endcase
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
          if (tick) begin
            case (mode_q)
              M_FILL: begin
                if (step_q == 5'd16) begin
                  led_d   = 16'h0000;
                  state_d = S_DONE;
                end else begin
                  led_d  = led_q | (16'h0001 << step_q[3:0]);
                  step_d = step_q + 5'd1;
                end
              end
              M_BLINK: begin
                // step[0]=0 shows the pattern, step[0]=1 shows blank
                led_d  = step_q[0] ? pat_q : 16'h0000;
                step_d = {4'd0, ~step_q[0]};
              end
              default: begin
                led_d  = {led_q[14:0], led_q[15]};
                step_d = {1'b0, step_q[3:0] + 4'd1};
              end
            endcase
          end
        end
      end
      S_DONE: begin
        led_d   = SW;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      led_q   <= 16'h0000;
      pat_q   <= 16'h0000;
      mode_q  <= 2'b00;
      step_q  <= 5'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LED  = led_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a TICK_DIV=4 instance for the pattern and
// control scenarios, plus a TICK_DIV=1 instance for the every-cycle tick case.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = 16'h0000;
  logic [1:0]  mode = 2'b00;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] led, led1;
  logic        busy, busy1, done, done1;
  logic [4:0]  step, step1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.TICK_DIV(4), .CNT_W(27)) dut (
    .clk(clk), .rst(rst), .SW(sw), .mode(mode), .start(start), .stop(stop),
    .LED(led), .busy(busy), .done(done), .step(step)
  );

  led_pattern_sequencer #(.TICK_DIV(1), .CNT_W(27)) dut1 (
    .clk(clk), .rst(rst), .SW(sw), .mode(mode), .start(start1), .stop(stop),
    .LED(led1), .busy(busy1), .done(done1), .step(step1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // advance one clock; sample and drive 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_led(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_step(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // compare LED at each of n ticks (4 cycles apart) against queued values
  task automatic check_ticks(input string name, input int n);
    for (int k = 1; k <= n; k++) begin
      repeat (4) cyc();
      exp_v = exp_q.pop_front();
      chk_led(name, led, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 16'hA5C3;
    cyc();
    cyc();
    chk_led("reset_led", led, 16'h0000);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_step("reset_step", step, 5'd0);
    rst = 1'b0;
    cyc();
    chk_led("idle_mirror", led, 16'hA5C3);
    chk_bit("idle_busy", busy, 1'b0);
  endtask

  task automatic test_mirror();
    for (int i = 0; i < 6; i++) begin
      sw = 16'($urandom_range(0, 65535));
      exp_q.push_back(sw);
      cyc();
      exp_v = exp_q.pop_front();
      chk_led("mirror", led, exp_v);
    end
  endtask

  task automatic test_fill();
    pulse_start(2'b00);
    chk_bit("fill_busy", busy, 1'b1);
    chk_led("fill_init", led, 16'h0000);
    for (int k = 1; k <= 16; k++) exp_q.push_back(16'((32'd1 << k) - 1));
    check_ticks("fill_tick", 2);
    chk_step("fill_step2", step, 5'd2);
    check_ticks("fill_tick", 14);
    chk_step("fill_step16", step, 5'd16);
    repeat (4) cyc();
    chk_bit("fill_done", done, 1'b1);
    chk_led("fill_done_led", led, 16'h0000);
    chk_bit("fill_done_busy", busy, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_bit("fill_done_pulse", done, 1'b0);
    chk_bit("fill_after_busy", busy, 1'b0);
    cyc();
    chk_led("fill_after_mirror", led, sw);
    chk_bit("fill_start_in_done_ignored", busy, 1'b0);
  endtask

  task automatic test_walk();
    logic [15:0] w;
    pulse_start(2'b01);
    chk_led("walk_init", led, 16'h0001);
    w = 16'h0001;
    for (int k = 1; k <= 16; k++) begin
      w = {w[14:0], w[15]};
      exp_q.push_back(w);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        mode = 2'b00;
        sw = 16'($urandom_range(0, 65535));
      end
      if (k == 5) begin
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
      end else begin
        repeat (4) cyc();
      end
      exp_v = exp_q.pop_front();
      chk_led("walk_tick", led, exp_v);
    end
    chk_step("walk_step_wrap", step, 5'd0);
    pulse_stop();
    chk_bit("walk_stop_busy", busy, 1'b0);
    chk_bit("walk_stop_done", done, 1'b0);
    cyc();
    chk_led("walk_stop_mirror", led, sw);
    chk_bit("walk_stop_no_done", done, 1'b0);
  endtask

  task automatic test_rotate();
    sw = 16'h8001;
    cyc();
    pulse_start(2'b11);
    chk_led("rot_init", led, 16'h8001);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0006);
    exp_q.push_back(16'h000C);
    check_ticks("rot_tick", 3);
    chk_step("rot_step", step, 5'd3);
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk_bit("run_start_stop_busy", busy, 1'b0);
    cyc();
  endtask

  task automatic test_blink();
    sw = 16'h00FF;
    cyc();
    pulse_start(2'b10);
    chk_led("blink_init", led, 16'h00FF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h0000);
    check_ticks("blink_tick", 3);
    chk_step("blink_step", step, 5'd1);
    pulse_stop();
    cyc();
  endtask

  task automatic test_start_stop_idle();
    sw = 16'h1234;
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk_bit("idle_start_stop_busy", busy, 1'b0);
    chk_led("idle_start_stop_led", led, 16'h1234);
    repeat (4) cyc();
    chk_bit("idle_start_stop_stays", busy, 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_start(2'b00);
    repeat (36) cyc();
    chk_led("mid_tick9", led, 16'h01FF);
    rst = 1'b1;
    start = 1'b1;
    cyc();
    rst = 1'b0;
    start = 1'b0;
    chk_led("mid_rst_led", led, 16'h0000);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_step("mid_rst_step", step, 5'd0);
    cyc();
    chk_bit("mid_rst_idle", busy, 1'b0);
  endtask

  task automatic test_tick1();
    mode = 2'b00;
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk_bit("t1_busy", busy1, 1'b1);
    cyc();
    chk_led("t1_tick1", led1, 16'h0001);
    repeat (15) cyc();
    chk_led("t1_tick16", led1, 16'hFFFF);
    chk_bit("t1_not_done_yet", done1, 1'b0);
    cyc();
    chk_bit("t1_done", done1, 1'b1);
    chk_led("t1_done_led", led1, 16'h0000);
    cyc();
    chk_bit("t1_done_pulse", done1, 1'b0);
    chk_bit("t1_idle", busy1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mirror();
    test_fill();
    test_walk();
    test_rotate();
    test_blink();
    test_start_stop_idle();
    test_reset_mid();
    test_tick1();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
